// File: rtl/alarma_pkg.sv
// Shared types and constants for the temperature alarm block.
package alarma_pkg;

    typedef enum logic [1:0] {
        NORMAL       = 2'd0,
        ADVERTENCIA  = 2'd1,
        ALARMA       = 2'd2,
        RECUPERACION = 2'd3
    } estado_t;

    // Signed tenths of a degree Celsius.
    typedef logic signed [10:0] temp_t;

    localparam int TEMP_MIN = -400;
    localparam int TEMP_MAX = 850;

endpackage

// File: rtl/detector_pico.sv
// Peak detector: loads the temperature on alarm entry, then keeps the
// maximum (high alarm) or minimum (low alarm) while tracking is enabled.
module detector_pico
    import alarma_pkg::*;
(
    input  logic  clk,
    input  logic  arst_n,
    input  logic  i_cargar,
    input  logic  i_seguir,
    input  logic  i_tipo,
    input  temp_t i_temp,
    output temp_t o_pico
);

    temp_t r_pico;

    // Load on entry has priority over tracking; holds otherwise.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_pico <= '0;
        end else if (i_cargar) begin
            r_pico <= i_temp;
        end else if (i_seguir) begin
            if (i_tipo ? (i_temp > r_pico) : (i_temp < r_pico))
                r_pico <= i_temp;
        end
    end

    assign o_pico = r_pico;

endmodule

// File: rtl/alarma_temp.sv
// Temperature alarm FSM with hysteresis, acknowledge and peak tracking.
// Build option: define ALARMA_AUTO_ACK_EN to leave recovery without an
// operator acknowledge (ack port stays in the port list, value ignored).
module alarma_temp
    import alarma_pkg::*;
#(
    parameter int PERSISTENCIA = 4,
    parameter int UMBRAL_ALTO  = 700,
    parameter int UMBRAL_BAJO  = -200,
    parameter int HISTERESIS   = 20,
    parameter int CICLOS_RECUP = 8
) (
    input  logic        clk,
    input  logic        arst_n,
    input  temp_t       temp_registrado,
    input  logic [2:0]  contador_fuera_rango,
    input  logic        ack,
    output logic        advertencia,
    output logic        alarma,
    output logic        tipo_alarma,
    output logic [1:0]  estado,
    output temp_t       temp_pico,
    output logic [7:0]  num_alarmas
);

    // Return-band limits in 12 bits so threshold +/- hysteresis cannot wrap.
    localparam logic signed [11:0] LIM_ALTO = 12'(UMBRAL_ALTO - HISTERESIS);
    localparam logic signed [11:0] LIM_BAJO = 12'(UMBRAL_BAJO + HISTERESIS);
    localparam temp_t              UMB_ALTO = 11'(UMBRAL_ALTO);
    localparam logic [2:0]         PERS     = 3'(PERSISTENCIA);
    localparam logic [7:0]         CREC     = 8'(CICLOS_RECUP);

    estado_t     r_estado;
    logic        r_advertencia;
    logic        r_alarma;
    logic        r_tipo;
    logic [7:0]  r_num;
    logic [7:0]  r_cnt_recup;
    logic        r_ack_visto;

    estado_t     w_sig;
    logic        w_entrada;
    logic [7:0]  w_cnt_sig;
    logic [7:0]  w_cnt_inc;
    logic        w_en_banda;
    logic        w_ack_ok;
    logic        w_en_alarma;
    logic signed [11:0] w_temp12;

    assign w_temp12    = {temp_registrado[10], temp_registrado};
    assign w_en_banda  = r_tipo ? (w_temp12 <= LIM_ALTO) : (w_temp12 >= LIM_BAJO);
    assign w_cnt_inc   = (r_cnt_recup >= CREC) ? CREC : r_cnt_recup + 8'd1;
    assign w_en_alarma = (r_estado == ALARMA) || (r_estado == RECUPERACION);

`ifdef ALARMA_AUTO_ACK_EN
    // Exit never waits for the operator; ack terms folded away.
    assign w_ack_ok = r_ack_visto | ack | 1'b1;
`else
    assign w_ack_ok = r_ack_visto | ack;
`endif

    // Next-state decision and recovery-count update.
    always_comb begin
        w_sig     = r_estado;
        w_entrada = 1'b0;
        w_cnt_sig = r_cnt_recup;
        case (r_estado)
            NORMAL: begin
                if (contador_fuera_rango != 3'd0)
                    w_sig = ADVERTENCIA;
            end
            ADVERTENCIA: begin
                // Upstream counter wraps 7->0; a 0 after 7 is a plain return.
                if (contador_fuera_rango == 3'd0) begin
                    w_sig = NORMAL;
                end else if (contador_fuera_rango >= PERS) begin
                    w_sig     = ALARMA;
                    w_entrada = 1'b1;
                end
            end
            ALARMA: begin
                if (w_en_banda) begin
                    w_sig     = RECUPERACION;
                    w_cnt_sig = 8'd1;
                end
            end
            RECUPERACION: begin
                // Falling back to ALARMA is not a new alarm entry.
                if (!w_en_banda) begin
                    w_sig = ALARMA;
                end else begin
                    w_cnt_sig = w_cnt_inc;
                    if ((w_cnt_inc == CREC) && w_ack_ok)
                        w_sig = NORMAL;
                end
            end
            default: w_sig = NORMAL;
        endcase
    end

    // State, registered outputs, alarm counter and acknowledge latch.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_estado      <= NORMAL;
            r_advertencia <= 1'b0;
            r_alarma      <= 1'b0;
            r_tipo        <= 1'b0;
            r_num         <= 8'd0;
            r_cnt_recup   <= 8'd0;
            r_ack_visto   <= 1'b0;
        end else begin
            r_estado      <= w_sig;
            r_advertencia <= (w_sig == ADVERTENCIA);
            r_alarma      <= (w_sig == ALARMA) || (w_sig == RECUPERACION);
            r_cnt_recup   <= w_cnt_sig;
            if (w_entrada) begin
                r_tipo      <= (temp_registrado > UMB_ALTO);
                r_ack_visto <= 1'b0;
                if (r_num != 8'd255)
                    r_num <= r_num + 8'd1;
            end else if (w_en_alarma && ack) begin
                r_ack_visto <= 1'b1;
            end
        end
    end

    detector_pico u_pico (
        .clk      (clk),
        .arst_n   (arst_n),
        .i_cargar (w_entrada),
        .i_seguir (w_en_alarma),
        .i_tipo   (r_tipo),
        .i_temp   (temp_registrado),
        .o_pico   (temp_pico)
    );

    assign advertencia = r_advertencia;
    assign alarma      = r_alarma;
    assign tipo_alarma = r_tipo;
    assign estado      = r_estado;
    assign num_alarmas = r_num;

endmodule
